// File: rtl/ad7656_pkg.sv
// ---------------------------------------------------------------------------
// ad7656_pkg
// Shared definitions for the AD7656 averaging packer:
//   NUM_CH      - number of ADC channels per frame
//   ADC_DW      - native AD7656 sample width
//   CHAN_W      - width of the output channel index
//   out_state_e - output stream FSM states
//   acc_width() - accumulator width needed to sum 2^avg_log2 samples
// ---------------------------------------------------------------------------
package ad7656_pkg;

    localparam int NUM_CH = 6;
    localparam int ADC_DW = 16;
    localparam int CHAN_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } out_state_e;

    // Summing 2^avg_log2 samples of dw bits needs avg_log2 extra bits.
    function automatic int acc_width(input int dw, input int avg_log2);
        return dw + avg_log2;
    endfunction

endpackage

// File: rtl/ad7656_ch_accum.sv
// ---------------------------------------------------------------------------
// ad7656_ch_accum
// One channel's block accumulator plus the final divide-by-2^AVG_LOG2.
// The average is produced combinationally from (acc + current sample) so the
// set is ready in the same cycle as the completing frame pulse.
//
// Ports:
//   clk      - system clock
//   rst      - asynchronous reset, active-high
//   en_i     - accumulation enable; low holds the accumulator at zero
//   add_i    - add sample_i this cycle (frame pulse while enabled)
//   last_i   - this add completes the set; accumulator restarts at zero
//   sample_i - signed channel sample
//   avg_o    - signed average of the accumulated set including sample_i
//
// Build option: AD7656_AVG_ROUND_EN selects round-half-up instead of floor.
// ---------------------------------------------------------------------------
module ad7656_ch_accum
    import ad7656_pkg::*;
#(
    parameter int DW       = ADC_DW,
    parameter int AVG_LOG2 = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic          add_i,
    input  logic          last_i,
    input  logic [DW-1:0] sample_i,
    output logic [DW-1:0] avg_o
);

    localparam int AW = acc_width(DW, AVG_LOG2);

`ifdef AD7656_AVG_ROUND_EN
    // Half an LSB of the result; evaluates to zero for pass-through.
    localparam logic signed [AW:0] RND = (AW+1)'((1 << AVG_LOG2) >> 1);
`else
    localparam logic signed [AW:0] RND = '0;
`endif

    logic signed [DW-1:0] sample_s;
    logic signed [AW-1:0] sum;
    logic signed [AW-1:0] acc_d;
    logic signed [AW-1:0] acc_q;

    // One guard bit keeps the rounding add from wrapping at full scale.
    function automatic logic signed [DW-1:0] scale_avg(input logic signed [AW-1:0] s);
        logic signed [AW:0] t;
        t = (AW+1)'(s) + RND;
        return DW'(t >>> AVG_LOG2);
    endfunction

    assign sample_s = $signed(sample_i);

    always_comb begin
        sum   = acc_q + AW'(sample_s);
        acc_d = acc_q;
        if (!en_i) begin
            acc_d = '0;
        end else if (add_i) begin
            acc_d = last_i ? '0 : sum;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign avg_o = scale_avg(sum);

endmodule

// File: rtl/ad7656_avg_packer.sv
// ---------------------------------------------------------------------------
// ad7656_avg_packer
// Block-averages 2^AVG_LOG2 AD7656 frames per channel and streams each
// averaged set as six valid/ready beats (ch1..ch6, last on ch6). Averaging
// keeps running while a set drains; a set that completes while the output
// buffer is still busy is dropped and flagged in overrun_o.
//
// Ports:
//   sys_clk_i            - system clock
//   rst_i                - asynchronous reset, active-high
//   enable_i             - accumulation enable; low clears accumulators/count
//   frame_done_i         - one-cycle pulse, channel data valid with it
//   ch1_data_i..ch6_data_i - signed channel samples
//   m_data_o/m_chan_o/m_last_o/m_valid_o/m_ready_i - output stream
//   overrun_o            - sticky dropped-set flag
//   overrun_clr_i        - clears overrun_o (a new drop in the same cycle wins)
//   set_cnt_o            - count of fully transferred sets, wraps
//
// Build option: AD7656_AVG_ROUND_EN selects round-half-up averaging.
// ---------------------------------------------------------------------------
module ad7656_avg_packer
    import ad7656_pkg::*;
#(
    parameter int AVG_LOG2 = 3,
    parameter int DW       = ADC_DW
) (
    input  logic              sys_clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              frame_done_i,
    input  logic [DW-1:0]     ch1_data_i,
    input  logic [DW-1:0]     ch2_data_i,
    input  logic [DW-1:0]     ch3_data_i,
    input  logic [DW-1:0]     ch4_data_i,
    input  logic [DW-1:0]     ch5_data_i,
    input  logic [DW-1:0]     ch6_data_i,
    output logic [DW-1:0]     m_data_o,
    output logic [CHAN_W-1:0] m_chan_o,
    output logic              m_last_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic              overrun_o,
    input  logic              overrun_clr_i,
    output logic [15:0]       set_cnt_o
);

    // Frame counter wide enough for AVG_LOG2 up to 8.
    localparam int                CW         = 9;
    localparam logic [CW-1:0]     LAST_FRAME = CW'((1 << AVG_LOG2) - 1);
    localparam logic [CHAN_W-1:0] LAST_CHAN  = CHAN_W'(NUM_CH - 1);

    logic [DW-1:0]     ch_data [NUM_CH];
    logic [DW-1:0]     avg     [NUM_CH];

    logic              add;
    logic              complete;
    logic              xfer;
    logic              last_xfer;
    logic              load;
    logic              drop;

    out_state_e        state_q, state_d;
    logic [CW-1:0]     frame_cnt_q, frame_cnt_d;
    logic [CHAN_W-1:0] chan_q, chan_d;
    logic              full_q, full_d;
    logic [DW-1:0]     buf_q [NUM_CH];
    logic [DW-1:0]     buf_d [NUM_CH];
    logic              overrun_q, overrun_d;
    logic [15:0]       set_cnt_q, set_cnt_d;

    assign ch_data[0] = ch1_data_i;
    assign ch_data[1] = ch2_data_i;
    assign ch_data[2] = ch3_data_i;
    assign ch_data[3] = ch4_data_i;
    assign ch_data[4] = ch5_data_i;
    assign ch_data[5] = ch6_data_i;

    // Per-channel accumulate and scale
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        ad7656_ch_accum #(
            .DW       (DW),
            .AVG_LOG2 (AVG_LOG2)
        ) u_accum (
            .clk      (sys_clk_i),
            .rst      (rst_i),
            .en_i     (enable_i),
            .add_i    (add),
            .last_i   (complete),
            .sample_i (ch_data[k]),
            .avg_o    (avg[k])
        );
    end

    // Set completion and handshake decode
    always_comb begin
        add       = frame_done_i && enable_i;
        complete  = add && (frame_cnt_q == LAST_FRAME);
        xfer      = (state_q == SEND) && m_ready_i;
        last_xfer = xfer && (chan_q == LAST_CHAN);
        // The buffer frees up in the same cycle its final beat leaves.
        load      = complete && (!full_q || last_xfer);
        drop      = complete && !load;
    end

    // Frame counter, buffer, channel pointer, status
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (!enable_i) begin
            frame_cnt_d = '0;
        end else if (add) begin
            frame_cnt_d = complete ? '0 : frame_cnt_q + 1'b1;
        end

        buf_d  = buf_q;
        full_d = full_q;
        chan_d = chan_q;
        if (load) begin
            buf_d  = avg;
            full_d = 1'b1;
            chan_d = '0;
        end else if (last_xfer) begin
            full_d = 1'b0;
        end else if (xfer) begin
            chan_d = chan_q + 1'b1;
        end

        overrun_d = overrun_q;
        if (drop) begin
            overrun_d = 1'b1;
        end else if (overrun_clr_i) begin
            overrun_d = 1'b0;
        end

        set_cnt_d = last_xfer ? set_cnt_q + 16'd1 : set_cnt_q;
    end

    // Output FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (load) state_d = SEND;
            SEND: if (last_xfer && !load) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output FSM: state register
    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            frame_cnt_q <= '0;
            chan_q      <= '0;
            full_q      <= 1'b0;
            overrun_q   <= 1'b0;
            set_cnt_q   <= '0;
            for (int k = 0; k < NUM_CH; k++) buf_q[k] <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            chan_q      <= chan_d;
            full_q      <= full_d;
            overrun_q   <= overrun_d;
            set_cnt_q   <= set_cnt_d;
            buf_q       <= buf_d;
        end
    end

    // Output FSM: outputs
    always_comb begin
        m_valid_o = (state_q == SEND);
        m_chan_o  = chan_q;
        m_last_o  = m_valid_o && (chan_q == LAST_CHAN);
        m_data_o  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (chan_q == CHAN_W'(k)) m_data_o = buf_q[k];
        end
        overrun_o = overrun_q;
        set_cnt_o = set_cnt_q;
    end

endmodule

// File: tb/tb_ad7656_avg_packer.sv
// ---------------------------------------------------------------------------
// tb_ad7656_avg_packer
// Three packer instances (8-frame, 2-frame and pass-through averaging) share
// the clock, reset and frame inputs; each scenario resets everything and then
// checks one instance against hand-computed values.
// ---------------------------------------------------------------------------
module tb_ad7656_avg_packer;

    localparam int DW = 16;
    localparam int D8 = 0;  // AVG_LOG2 = 3
    localparam int D2 = 1;  // AVG_LOG2 = 1
    localparam int D1 = 2;  // AVG_LOG2 = 0

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b1;
    logic          frame_done = 1'b0;
    logic          ovr_clr = 1'b0;
    logic [DW-1:0] ch0 = '0, ch1 = '0, ch2 = '0, ch3 = '0, ch4 = '0, ch5 = '0;

    logic          r8 = 1'b1, r2 = 1'b1, r1 = 1'b1;
    logic [DW-1:0] d8, d2, d1;
    logic [2:0]    c8, c2, c1;
    logic          l8, l2, l1, v8, v2, v1, o8, o2, o1;
    logic [15:0]   s8, s2, s1;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q [6];

    always #5 clk = ~clk;

    ad7656_avg_packer #(.AVG_LOG2(3), .DW(DW)) u_avg8 (
        .sys_clk_i(clk), .rst_i(rst), .enable_i(enable), .frame_done_i(frame_done),
        .ch1_data_i(ch0), .ch2_data_i(ch1), .ch3_data_i(ch2),
        .ch4_data_i(ch3), .ch5_data_i(ch4), .ch6_data_i(ch5),
        .m_data_o(d8), .m_chan_o(c8), .m_last_o(l8), .m_valid_o(v8), .m_ready_i(r8),
        .overrun_o(o8), .overrun_clr_i(ovr_clr), .set_cnt_o(s8));

    ad7656_avg_packer #(.AVG_LOG2(1), .DW(DW)) u_avg2 (
        .sys_clk_i(clk), .rst_i(rst), .enable_i(enable), .frame_done_i(frame_done),
        .ch1_data_i(ch0), .ch2_data_i(ch1), .ch3_data_i(ch2),
        .ch4_data_i(ch3), .ch5_data_i(ch4), .ch6_data_i(ch5),
        .m_data_o(d2), .m_chan_o(c2), .m_last_o(l2), .m_valid_o(v2), .m_ready_i(r2),
        .overrun_o(o2), .overrun_clr_i(ovr_clr), .set_cnt_o(s2));

    ad7656_avg_packer #(.AVG_LOG2(0), .DW(DW)) u_avg1 (
        .sys_clk_i(clk), .rst_i(rst), .enable_i(enable), .frame_done_i(frame_done),
        .ch1_data_i(ch0), .ch2_data_i(ch1), .ch3_data_i(ch2),
        .ch4_data_i(ch3), .ch5_data_i(ch4), .ch6_data_i(ch5),
        .m_data_o(d1), .m_chan_o(c1), .m_last_o(l1), .m_valid_o(v1), .m_ready_i(r1),
        .overrun_o(o1), .overrun_clr_i(ovr_clr), .set_cnt_o(s1));

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input int a, input int b, input int c,
                         input int d, input int e, input int f);
        ch0 = 16'(a); ch1 = 16'(b); ch2 = 16'(c);
        ch3 = 16'(d); ch4 = 16'(e); ch5 = 16'(f);
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
    endtask

    task automatic frames(input int n, input int v);
        for (int i = 0; i < n; i++) frame(v, v, v, v, v, v);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic sample(input int d, output int data, output int chan, output int last,
                          output int valid, output int ovr, output int cnt);
        case (d)
            D8:      begin data = int'($signed(d8)); chan = int'(c8); last = int'(l8);
                           valid = int'(v8); ovr = int'(o8); cnt = int'(s8); end
            D2:      begin data = int'($signed(d2)); chan = int'(c2); last = int'(l2);
                           valid = int'(v2); ovr = int'(o2); cnt = int'(s2); end
            default: begin data = int'($signed(d1)); chan = int'(c1); last = int'(l1);
                           valid = int'(v1); ovr = int'(o1); cnt = int'(s1); end
        endcase
    endtask

    task automatic set_ready(input int d, input logic r);
        case (d)
            D8:      r8 = r;
            D2:      r2 = r;
            default: r1 = r;
        endcase
    endtask

    // Collect six beats of one set and compare them against exp_q.
    task automatic drain(input int d, input bit rnd, input string tag);
        int   idx = 0;
        int   data, chan, last, valid, ovr, cnt;
        logic r;
        for (int cyc = 0; cyc < 200 && idx < 6; cyc++) begin
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            set_ready(d, r);
            sample(d, data, chan, last, valid, ovr, cnt);
            if (valid == 1 && r) begin
                check({tag, "_chan"}, chan, idx);
                check({tag, "_data"}, data, exp_q[idx]);
                check({tag, "_last"}, last, int'(idx == 5));
                idx++;
            end
            tick();
        end
        if (idx < 6) check({tag, "_timeout"}, idx, 6);
        set_ready(d, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int data, chan, last, valid, ovr, cnt;
        int a [6];
        int b [6];
        int sum;
        logic signed [15:0] t;

        // Reset state
        do_reset();
        sample(D8, data, chan, last, valid, ovr, cnt);
        check("rst_valid", valid, 0);
        check("rst_data", data, 0);
        check("rst_chan", chan, 0);
        check("rst_last", last, 0);
        check("rst_ovr", ovr, 0);
        check("rst_cnt", cnt, 0);

        // 8-frame average, ch1 = 100, others 0
        do_reset();
        for (int i = 0; i < 7; i++) frame(100, 0, 0, 0, 0, 0);
        sample(D8, data, chan, last, valid, ovr, cnt);
        check("avg8_early_valid", valid, 0);
        frame(100, 0, 0, 0, 0, 0);
        sample(D8, data, chan, last, valid, ovr, cnt);
        check("avg8_latency_valid", valid, 1);
        exp_q = '{100, 0, 0, 0, 0, 0};
        drain(D8, 1'b0, "avg8");
        sample(D8, data, chan, last, valid, ovr, cnt);
        check("avg8_idle", valid, 0);
        check("avg8_setcnt", cnt, 1);

        // 2-frame average: negative floor/round and positive full scale
        do_reset();
        frame(0, -3, 32767, 0, 0, 0);
        frame(0, -2, 32767, 0, 0, 0);
`ifdef AD7656_AVG_ROUND_EN
        exp_q = '{0, -2, 32767, 0, 0, 0};
`else
        exp_q = '{0, -3, 32767, 0, 0, 0};
`endif
        drain(D2, 1'b0, "avg2");

        // Pass-through with ready low: hold, drop, overrun clear
        do_reset();
        r1 = 1'b0;
        frame(11, 12, 13, 14, 15, 16);
        sample(D1, data, chan, last, valid, ovr, cnt);
        check("hold_valid", valid, 1);
        check("hold_chan", chan, 0);
        check("hold_data", data, 11);
        check("hold_ovr0", ovr, 0);
        tick(); tick(); tick();
        sample(D1, data, chan, last, valid, ovr, cnt);
        check("hold_valid_stable", valid, 1);
        check("hold_data_stable", data, 11);
        frame(21, 22, 23, 24, 25, 26);
        sample(D1, data, chan, last, valid, ovr, cnt);
        check("drop_ovr", ovr, 1);
        check("drop_chan", chan, 0);
        check("drop_data", data, 11);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        sample(D1, data, chan, last, valid, ovr, cnt);
        check("ovr_clr", ovr, 0);
        exp_q = '{11, 12, 13, 14, 15, 16};
        drain(D1, 1'b0, "held_set");
        sample(D1, data, chan, last, valid, ovr, cnt);
        check("held_idle", valid, 0);
        check("held_setcnt", cnt, 1);

        // Pass-through back-to-back: new set lands on the chan5 transfer
        do_reset();
        frame(1, 2, 3, 4, 5, 6);
        for (int i = 0; i < 5; i++) begin
            sample(D1, data, chan, last, valid, ovr, cnt);
            check("b2b_chan", chan, i);
            check("b2b_data", data, i + 1);
            tick();
        end
        sample(D1, data, chan, last, valid, ovr, cnt);
        check("b2b_chan5", chan, 5);
        check("b2b_last5", last, 1);
        frame(7, 8, 9, 10, 11, 12);
        sample(D1, data, chan, last, valid, ovr, cnt);
        check("b2b_nobubble", valid, 1);
        check("b2b_chan0", chan, 0);
        check("b2b_data0", data, 7);
        check("b2b_ovr", ovr, 0);
        check("b2b_cnt1", cnt, 1);
        exp_q = '{7, 8, 9, 10, 11, 12};
        drain(D1, 1'b0, "b2b_set2");
        sample(D1, data, chan, last, valid, ovr, cnt);
        check("b2b_cnt2", cnt, 2);

        // 100 random 2-frame sets under random backpressure
        do_reset();
        for (int s = 0; s < 100; s++) begin
            for (int k = 0; k < 6; k++) begin
                t = 16'($urandom); a[k] = int'(t);
                t = 16'($urandom); b[k] = int'(t);
            end
            frame(a[0], a[1], a[2], a[3], a[4], a[5]);
            frame(b[0], b[1], b[2], b[3], b[4], b[5]);
            for (int k = 0; k < 6; k++) begin
                sum = a[k] + b[k];
`ifdef AD7656_AVG_ROUND_EN
                sum = sum + 1;
`endif
                exp_q[k] = sum >>> 1;
            end
            drain(D2, 1'b1, "rnd");
            repeat ($urandom_range(0, 2)) tick();
        end
        sample(D2, data, chan, last, valid, ovr, cnt);
        check("rnd_setcnt", cnt, 100);
        check("rnd_ovr", ovr, 0);

        // Enable low discards a partial sum and ignores frames
        do_reset();
        frames(5, 999);
        enable = 1'b0;
        tick();
        frame(5000, 5000, 5000, 5000, 5000, 5000);
        tick();
        enable = 1'b1;
        frames(7, 40);
        sample(D8, data, chan, last, valid, ovr, cnt);
        check("en_no_early_set", valid, 0);
        frames(1, 40);
        sample(D8, data, chan, last, valid, ovr, cnt);
        check("en_set_valid", valid, 1);
        exp_q = '{40, 40, 40, 40, 40, 40};
        drain(D8, 1'b0, "en40");

        // Reset in the middle of a held set with a partial sum pending
        do_reset();
        frames(8, 40);
        drain(D8, 1'b0, "pre_rst");
        r8 = 1'b0;
        frames(8, 7);
        frames(3, 1000);
        sample(D8, data, chan, last, valid, ovr, cnt);
        check("pre_rst_valid", valid, 1);
        check("pre_rst_cnt", cnt, 1);
        #2;
        rst = 1'b1;
        #1;
        sample(D8, data, chan, last, valid, ovr, cnt);
        check("mid_rst_valid", valid, 0);
        check("mid_rst_chan", chan, 0);
        check("mid_rst_data", data, 0);
        check("mid_rst_cnt", cnt, 0);
        tick();
        rst = 1'b0;
        r8 = 1'b1;
        frames(8, 40);
        sample(D8, data, chan, last, valid, ovr, cnt);
        check("post_rst_valid", valid, 1);
        exp_q = '{40, 40, 40, 40, 40, 40};
        drain(D8, 1'b0, "post_rst");
        sample(D8, data, chan, last, valid, ovr, cnt);
        check("post_rst_cnt", cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ad7656_avg_packer.md
Name: ad7656_avg_packer

Overview:
Downstream consumer of the AD7656 read driver. Takes the six 16-bit channel words and the one-cycle frame-done pulse, and block-averages 2^AVG_LOG2 frames per channel. Each averaged set is presented as a 6-beat valid/ready stream (ch1..ch6, last on ch6) to the capture/DMA logic. Accumulation continues while a set drains; a set completing into an occupied buffer is dropped and flagged.

Parameters:
AVG_LOG2, 3, log2 of frames averaged per output set; legal 0..8 (0 = pass-through, one set per frame)
DW, 16, ADC sample width (two's complement)

Ports:
sys_clk_i  in  1  100 MHz system clock
rst_i  in  1  asynchronous reset, active-high
enable_i  in  1  accumulation enable; low clears accumulators and frame counter
frame_done_i  in  1  one-cycle pulse; ch*_data_i valid in that cycle
ch1_data_i..ch6_data_i  in  DW each  channel samples, signed
m_data_o  out  DW  averaged sample, signed
m_chan_o  out  3  channel index 0..5
m_last_o  out  1  high on the ch6 beat
m_valid_o  out  1  stream valid
m_ready_i  in  1  stream ready
overrun_o  out  1  sticky: a completed set was dropped
overrun_clr_i  in  1  clears overrun_o
set_cnt_o  out  16  completed sets transferred, wraps at 65535->0

Behaviour:
- Reset: all outputs 0, accumulators 0, frame_cnt 0, buffer empty.
- Accumulators: six signed regs, width DW+AVG_LOG2. frame_done_i && enable_i -> acc[k] <= acc[k] + sext(ch_k); frame_cnt++.
- Set completion: frame_done_i && enable_i && frame_cnt == 2^AVG_LOG2-1 -> avg[k] = (acc[k] + sext(ch_k)) >>> AVG_LOG2 (arithmetic shift, truncation toward -inf), computed in the same cycle. Accumulators reset to 0 and frame_cnt to 0 next cycle regardless of whether the set is accepted.
- Buffer: six DW regs plus full flag. A completed set loads if the buffer is empty, or if the final beat (chan 5) transfers in the same cycle. Otherwise the set is dropped and overrun_o <= 1. overrun_clr_i and a simultaneous overrun: set wins.
- Output FSM, states IDLE, SEND:
  - IDLE: buffer load -> SEND next cycle with m_valid_o=1, m_chan_o=0, m_data_o=avg[0]. Latency is 1 cycle from the completing frame_done_i to m_valid_o.
  - SEND: beat transfers when m_valid_o && m_ready_i; chan increments. m_data_o/m_chan_o are held stable while m_valid_o && !m_ready_i.
  - Transfer on chan 5: set_cnt_o++. If a new set loads in the same cycle, stay in SEND with chan 0 (back-to-back, no bubble); else go to IDLE with m_valid_o=0 next cycle.
- m_valid_o never drops without a transfer. m_last_o = (m_chan_o==5) && m_valid_o.
- enable_i low: accumulators and frame_cnt held at 0; frame_done_i ignored. A set already in the buffer drains normally.
- frame_done_i while enable_i rises same cycle: counted.
- Reset mid-stream: everything returns to reset state immediately; partial set lost.
- Overflow-free: |avg| <= 2^(DW-1) by construction, so no saturation is needed.

Optional Feature:
Macro AD7656_AVG_ROUND_EN.
- Defined: adds 2^(AVG_LOG2-1) before the shift (round half up). No effect when AVG_LOG2=0. Max result 32767 is still representable.
- Undefined: plain arithmetic shift (floor).

Decomposition:
- Package ad7656_pkg: NUM_CH=6, ADC_DW=16, CHAN_W=3, output FSM state enum (IDLE, SEND), helper for accumulator width.
- Sub-module ad7656_ch_accum: one channel's accumulator plus shift/round, instantiated 6 times. The frame counter, buffer and FSM stay in the top.

Test Plan:
- AVG_LOG2=3, ch1=100 for 8 frames, others 0; ready tied 1 -> beats chan 0..5 data 100,0,0,0,0,0; last on chan5; set_cnt_o=1; m_valid_o 1 cycle after 8th pulse.
- AVG_LOG2=1, ch2 = -3 then -2 -> avg -3 (floor). With AD7656_AVG_ROUND_EN -> -2. ch3 = 32767 x2 -> 32767 both builds.
- AVG_LOG2=0, ready low throughout, 2 frame pulses -> first set held on chan0 with stable data; second dropped; overrun_o=1. overrun_clr_i pulse -> 0.
- AVG_LOG2=0, ready=1, frame pulses every 6 cycles, second pulse coincides with the chan5 transfer -> second set starts chan0 next cycle, no bubble, no overrun; set_cnt_o=2.
- Random ready backpressure over 100 sets vs reference model -> all data/chan/last match, set_cnt_o=100.
- enable_i low after 5 of 8 frames, then high and 8 frames of value 40 -> output 40 (partial sum discarded). rst_i mid-stream -> m_valid_o=0 immediately, all counters 0.
